// File: rtl/bpred_pkg.sv
// Shared branch-prediction definitions: 2-bit saturating counter encodings and the
// counter step, reused by any predictor that keeps per-entry direction counters.
package bpred_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Move one step towards the resolved direction, sticking at either end.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup for fetch,
// one registered training update per cycle from decode, and a saturating mispredict count.
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_f,
  input  logic             branch_f,
  output logic             predict_taken_f,
  output logic [31:0]      predict_target_f,
  input  logic             update_en,
  input  logic [31:0]      update_pc,
  input  logic             update_taken,
  input  logic [31:0]      update_target,
  input  logic             update_mispredict,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int TAG_W = 30 - IDX_W;

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $fatal(1, "branch_predictor: ENTRIES must be a power of two and at least 2");
  end

  // Flop arrays rather than RAM: the fetch lookup has to be asynchronous.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_low_bits;

  assign unused_low_bits = ^{pc_f[1:0], update_pc[1:0]};

  assign lk_idx = pc_f[IDX_W+1:2];
  assign lk_tag = pc_f[31:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign predict_taken_f  = branch_f && lk_hit && ctr_q[lk_idx][1];
  assign predict_target_f = lk_hit ? target_q[lk_idx] : 32'h0;

  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Training: hits step the counter, taken misses (re)allocate, not-taken misses are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (update_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], update_taken);
        if (update_taken) begin
          target_q[up_idx] <= update_target;
        end
      end else if (update_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (update_en && update_mispredict && !(&mispredict_count)) begin
      mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64, CNT_W=2 so the
// mispredict counter saturation is reachable in a few updates).
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pc_f;
  logic        branch_f;
  logic        predict_taken_f;
  logic [31:0] predict_target_f;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic [1:0]  mispredict_count;

  int n_checks = 0;
  int n_fails  = 0;

  branch_predictor #(.ENTRIES(64), .CNT_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_f              (pc_f),
    .branch_f          (branch_f),
    .predict_taken_f   (predict_taken_f),
    .predict_target_f  (predict_target_f),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .mispredict_count  (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One training update held across a single posedge, then removed.
  task automatic apply_stimulus(input logic [31:0] pc, input logic taken,
                                input logic [31:0] target, input logic mispredict);
    update_en         = 1'b1;
    update_pc         = pc;
    update_taken      = taken;
    update_target     = target;
    update_mispredict = mispredict;
    next_cycle();
    update_en         = 1'b0;
    update_mispredict = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic br);
    pc_f     = pc;
    branch_f = br;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pc_f = 32'h0; branch_f = 1'b0;
    update_en = 1'b0; update_pc = 32'h0; update_taken = 1'b0;
    update_target = 32'h0; update_mispredict = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    $display("[TB] reset state");
    lookup(32'h100, 1'b1);
    check_output("rst_taken",  32'(predict_taken_f),  32'h0);
    check_output("rst_target", predict_target_f,      32'h0);
    check_output("rst_count",  32'(mispredict_count), 32'h0);

    $display("[TB] allocate on taken miss");
    apply_stimulus(32'h100, 1'b1, 32'h200, 1'b1);
    lookup(32'h100, 1'b1);
    check_output("alloc_taken",  32'(predict_taken_f),  32'h1);
    check_output("alloc_target", predict_target_f,      32'h200);
    check_output("alloc_count",  32'(mispredict_count), 32'h1);
    lookup(32'h100, 1'b0);
    check_output("nobranch_taken",  32'(predict_taken_f), 32'h0);
    check_output("nobranch_target", predict_target_f,     32'h200);

    $display("[TB] counter walk");
    apply_stimulus(32'h100, 1'b0, 32'h999, 1'b0);
    lookup(32'h100, 1'b1);
    check_output("wnt_taken",  32'(predict_taken_f), 32'h0);
    check_output("wnt_target", predict_target_f,     32'h200);
    apply_stimulus(32'h100, 1'b0, 32'h999, 1'b0);
    lookup(32'h100, 1'b1);
    check_output("snt_taken", 32'(predict_taken_f), 32'h0);
    apply_stimulus(32'h100, 1'b1, 32'h200, 1'b0);
    lookup(32'h100, 1'b1);
    check_output("snt_to_wnt_taken", 32'(predict_taken_f), 32'h0);
    apply_stimulus(32'h100, 1'b1, 32'h200, 1'b0);
    lookup(32'h100, 1'b1);
    check_output("wnt_to_wt_taken", 32'(predict_taken_f), 32'h1);
    check_output("walk_count", 32'(mispredict_count), 32'h1);

    $display("[TB] aliasing on index 0");
    lookup(32'h200, 1'b1);
    check_output("alias_miss_taken",  32'(predict_taken_f), 32'h0);
    check_output("alias_miss_target", predict_target_f,     32'h0);
    apply_stimulus(32'h200, 1'b1, 32'h300, 1'b0);
    lookup(32'h200, 1'b1);
    check_output("alias_new_taken",  32'(predict_taken_f), 32'h1);
    check_output("alias_new_target", predict_target_f,     32'h300);
    lookup(32'h100, 1'b1);
    check_output("alias_old_taken",  32'(predict_taken_f), 32'h0);
    check_output("alias_old_target", predict_target_f,     32'h0);

    $display("[TB] same-cycle update and lookup");
    apply_stimulus(32'h100, 1'b1, 32'h200, 1'b0);
    update_en = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h400;
    lookup(32'h100, 1'b1);
    check_output("same_cycle_old_target", predict_target_f, 32'h200);
    next_cycle();
    update_en = 1'b0;
    #1;
    check_output("same_cycle_new_target", predict_target_f,     32'h400);
    check_output("same_cycle_new_taken",  32'(predict_taken_f), 32'h1);

    $display("[TB] hold while update_en low");
    update_pc = 32'h100; update_taken = 1'b0; update_target = 32'hdead_beef; update_mispredict = 1'b1;
    next_cycle();
    next_cycle();
    update_mispredict = 1'b0;
    lookup(32'h103, 1'b1);
    check_output("hold_target", predict_target_f,      32'h400);
    check_output("hold_taken",  32'(predict_taken_f),  32'h1);
    check_output("hold_count",  32'(mispredict_count), 32'h1);

    $display("[TB] mispredict count saturation");
    apply_stimulus(32'h500, 1'b0, 32'h0, 1'b1);
    check_output("count_2", 32'(mispredict_count), 32'h2);
    apply_stimulus(32'h500, 1'b0, 32'h0, 1'b1);
    check_output("count_3", 32'(mispredict_count), 32'h3);
    apply_stimulus(32'h500, 1'b0, 32'h0, 1'b1);
    apply_stimulus(32'h500, 1'b0, 32'h0, 1'b1);
    check_output("count_sat", 32'(mispredict_count), 32'h3);
    lookup(32'h500, 1'b1);
    check_output("nt_miss_no_alloc", predict_target_f, 32'h0);

    $display("[TB] asynchronous reset mid-cycle");
    lookup(32'h100, 1'b1);
    check_output("pre_reset_taken", 32'(predict_taken_f), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_rst_count",  32'(mispredict_count), 32'h0);
    check_output("async_rst_taken",  32'(predict_taken_f),  32'h0);
    check_output("async_rst_target", predict_target_f,      32'h0);
    #1;
    reset = 1'b0;
    next_cycle();
    lookup(32'h100, 1'b1);
    check_output("post_rst_target_100", predict_target_f,     32'h0);
    check_output("post_rst_taken_100",  32'(predict_taken_f), 32'h0);
    lookup(32'h200, 1'b1);
    check_output("post_rst_target_200", predict_target_f,     32'h0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
